// File: rtl/operand_fwd_ctrl_pkg.sv
// Shared types for the operand forwarding path: select encoding used by both
// this controller and the ALU operand mux, plus the per-stage tracking entry.
// Optional statistics counters are enabled with FWD_STATS_EN (see top).
package types_pkg;

  localparam int RW_DEFAULT = 4;
  // Tracking entries hold up to RW_MAX index bits so one struct serves any RW.
  localparam int RW_MAX     = 8;

  typedef enum logic [1:0] {
    A_SEL = 2'b00,  // register file
    C_SEL = 2'b01,  // EX-stage result
    B_SEL = 2'b10   // MEM-stage result
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [RW_MAX-1:0] rd;
    logic              wr;
    logic              load;
  } stage_entry_t;

endpackage

// File: rtl/operand_fwd_ctrl_if.sv
// Decode-side bus of the forwarding controller. master = decode/pipeline,
// slave = operand_fwd_ctrl. Counter signals exist only with FWD_STATS_EN.
interface operand_fwd_ctrl_if
  import types_pkg::*;
#(
  parameter int RW = RW_DEFAULT
);
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic [RW-1:0] id_rd;
  logic          id_wr_en;
  logic          id_is_load;
  logic          ex_flush;
  logic [1:0]    sel_a;
  logic [1:0]    sel_b;
  logic          stall;
`ifdef FWD_STATS_EN
  logic [15:0]   fwd_count;
  logic [15:0]   stall_count;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_wr_en, id_is_load, ex_flush,
    input  sel_a, sel_b, stall
`ifdef FWD_STATS_EN
    , input fwd_count, stall_count
`endif
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_wr_en, id_is_load, ex_flush,
    output sel_a, sel_b, stall
`ifdef FWD_STATS_EN
    , output fwd_count, stall_count
`endif
  );
endinterface

// File: rtl/operand_fwd_ctrl_fwd_match.sv
// Combinational comparator: does a tracked stage entry produce the value a
// source operand reads? Index 0 is never matched when ZERO_REG is set.
module fwd_match
  import types_pkg::*;
#(
  parameter int RW       = RW_DEFAULT,
  parameter int ZERO_REG = 1
) (
  input  stage_entry_t  entry,
  input  logic [RW-1:0] src,
  output logic          match
);
  logic src_zero;

  assign src_zero = (ZERO_REG != 0) && (src == '0);
  assign match    = entry.valid & entry.wr & (entry.rd == RW_MAX'(src)) & ~src_zero;
endmodule

// File: rtl/operand_fwd_ctrl.sv
// Operand forwarding controller: tracks EX/MEM destinations, drives the 2-bit
// operand mux selects and a one-cycle load-use stall.
// Build option FWD_STATS_EN adds fwd_count / stall_count on the bus.
module operand_fwd_ctrl
  import types_pkg::*;
#(
  parameter int RW       = RW_DEFAULT,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  operand_fwd_ctrl_if.slave  bus
);
  stage_entry_t           ex_q, mem_q;
  logic [1:0][RW-1:0]     src;
  logic [1:0]             m_ex, m_mem;
  logic                   stall;
  fwd_sel_e [1:0]         sel;

  assign src[0] = bus.id_rs1;
  assign src[1] = bus.id_rs2;

  // One comparator pair per operand: against EX and against MEM.
  for (genvar g = 0; g < 2; g++) begin : g_op
    fwd_match #(.RW(RW), .ZERO_REG(ZERO_REG)) u_ex  (.entry(ex_q),  .src(src[g]), .match(m_ex[g]));
    fwd_match #(.RW(RW), .ZERO_REG(ZERO_REG)) u_mem (.entry(mem_q), .src(src[g]), .match(m_mem[g]));
  end

  // A load in EX cannot forward yet; hold decode one cycle so it reaches MEM.
  assign stall = bus.id_valid & ex_q.load & (|m_ex);

  // Per-operand select: youngest producer wins, nothing forwarded while stalled.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sel[i] = A_SEL;
      if (bus.id_valid && !stall) begin
        if (m_ex[i] && !ex_q.load) sel[i] = C_SEL;
        else if (m_mem[i])         sel[i] = B_SEL;
      end
    end
  end

  assign bus.sel_a = sel[0];
  assign bus.sel_b = sel[1];
  assign bus.stall = stall;

  // Tracking pipeline; stall and flush both turn the EX entry into a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      mem_q       <= ex_q;
      ex_q.valid  <= bus.id_valid & ~stall & ~bus.ex_flush;
      ex_q.rd     <= RW_MAX'(bus.id_rd);
      ex_q.wr     <= bus.id_wr_en;
      ex_q.load   <= bus.id_is_load;
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] fwd_cnt_q, stall_cnt_q;

  // Free-running wrap-around counters of forwarded operands and stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_q + 16'(sel[0] != A_SEL) + 16'(sel[1] != A_SEL);
      stall_cnt_q <= stall_cnt_q + 16'(stall);
    end
  end

  assign bus.fwd_count   = fwd_cnt_q;
  assign bus.stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Directed bench for operand_fwd_ctrl: vector table plus hand-written
// reset / counter sequences. Counter checks compile in with FWD_STATS_EN.
module tb_operand_fwd_ctrl;
  import types_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_fwd_ctrl_if #(.RW(4)) bus ();
  operand_fwd_ctrl #(.RW(4), .ZERO_REG(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       v;
    logic [3:0] rs1, rs2, rd;
    logic       wr, ld, fl;
    logic [1:0] sa, sb;
    logic       st;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic v, input logic [3:0] rs1, rs2, rd,
                              input logic wr, ld, fl,
                              input logic [1:0] sa, sb, input logic st);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
    r.wr = wr; r.ld = ld; r.fl = fl;
    r.sa = sa; r.sb = sb; r.st = st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] r1, r2, rd,
                       input logic wr, ld, fl);
    bus.id_valid   = v;
    bus.id_rs1     = r1;
    bus.id_rs2     = r2;
    bus.id_rd      = rd;
    bus.id_wr_en   = wr;
    bus.id_is_load = ld;
    bus.ex_flush   = fl;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] sa, sb, input logic st);
    chk({tag, ".sel_a"}, 16'(bus.sel_a), 16'(sa));
    chk({tag, ".sel_b"}, 16'(bus.sel_b), 16'(sb));
    chk({tag, ".stall"}, 16'(bus.stall), 16'(st));
  endtask

  initial begin
    //            v  rs1 rs2 rd  wr ld fl   sa     sb     st
    tbl[0]  = mk(1, 1,  2,  3,  1, 0, 0, 2'b00, 2'b00, 0);
    tbl[1]  = mk(1, 3,  0,  4,  0, 0, 0, 2'b01, 2'b00, 0); // EX fwd, r0 ignored
    tbl[2]  = mk(1, 3,  3,  5,  1, 0, 0, 2'b10, 2'b10, 0); // MEM fwd, rs1==rs2
    tbl[3]  = mk(1, 0,  6,  5,  1, 0, 0, 2'b00, 2'b00, 0);
    tbl[4]  = mk(1, 1,  5,  8,  1, 0, 0, 2'b00, 2'b01, 0); // EX beats MEM
    tbl[5]  = mk(1, 2,  5,  1,  1, 0, 0, 2'b00, 2'b10, 0); // MEM only
    tbl[6]  = mk(1, 2,  2,  7,  1, 1, 0, 2'b00, 2'b00, 0); // load rd=7
    tbl[7]  = mk(1, 7,  1,  2,  1, 0, 0, 2'b00, 2'b00, 1); // load-use stall
    tbl[8]  = mk(1, 7,  1,  2,  1, 0, 0, 2'b10, 2'b00, 0); // replay: MEM fwd
    tbl[9]  = mk(1, 4,  4,  0,  1, 1, 0, 2'b00, 2'b00, 0); // load to r0
    tbl[10] = mk(1, 0,  0,  0,  1, 1, 0, 2'b00, 2'b00, 0); // r0 never stalls
    tbl[11] = mk(1, 0,  0,  9,  1, 0, 1, 2'b00, 2'b00, 0); // rd=9 flushed
    tbl[12] = mk(1, 9,  9,  10, 1, 0, 0, 2'b00, 2'b00, 0); // no fwd from bubble
    tbl[13] = mk(0, 10, 10, 11, 1, 0, 0, 2'b00, 2'b00, 0); // invalid decode
    tbl[14] = mk(1, 10, 11, 12, 1, 0, 0, 2'b10, 2'b00, 0); // rd=11 was invalid
    tbl[15] = mk(1, 3,  3,  6,  1, 1, 0, 2'b00, 2'b00, 0); // load rd=6
    tbl[16] = mk(1, 12, 6,  13, 1, 0, 1, 2'b00, 2'b00, 1); // stall + flush
    tbl[17] = mk(1, 12, 6,  13, 1, 0, 0, 2'b00, 2'b10, 0);
    tbl[18] = mk(1, 13, 13, 14, 1, 0, 0, 2'b01, 2'b01, 0);
    tbl[19] = mk(0, 14, 0,  0,  0, 0, 0, 2'b00, 2'b00, 0);
    tbl[20] = mk(1, 14, 13, 15, 0, 0, 0, 2'b10, 2'b00, 0);

    // Reset held with a live decode that would otherwise look like a hazard.
    drive(1, 3, 3, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 check_outs("reset", 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wr, tbl[i].ld, tbl[i].fl);
      #1 check_outs($sformatf("vec%0d", i), tbl[i].sa, tbl[i].sb, tbl[i].st);
    end

    // Reset mid-operation wipes a pending load-use hazard immediately.
    @(negedge clk);
    drive(1, 0, 0, 3, 1, 1, 0);
    @(negedge clk);
    drive(1, 3, 3, 4, 1, 0, 0);
    #1 check_outs("mid_pre", 2'b00, 2'b00, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_outs("mid_rst", 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 3, 3, 3, 1, 0, 0);
    #1 check_outs("post_rst", 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    drive(1, 3, 5, 6, 1, 0, 0);
    #1 check_outs("post_rst_fwd", 2'b01, 2'b00, 1'b0);

`ifdef FWD_STATS_EN
    // Three cycles forwarding both operands, then one load-use stall.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); drive(1, 1, 2, 5, 1, 0, 0);
    repeat (3) begin @(negedge clk); drive(1, 5, 5, 5, 1, 0, 0); end
    @(negedge clk); drive(1, 0, 0, 7, 1, 1, 0);
    @(negedge clk); drive(1, 7, 0, 8, 1, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fwd_count", bus.fwd_count, 16'd6);
    chk("stall_count", bus.stall_count, 16'd1);

    // Drive the forward counter up to 16'hFFFF, then one more to wrap.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); drive(1, 1, 2, 5, 1, 0, 0);
    repeat (32767) begin @(negedge clk); drive(1, 5, 5, 5, 1, 0, 0); end
    @(negedge clk); drive(1, 5, 1, 5, 1, 0, 0);
    @(negedge clk);
    #1 chk("fwd_count_max", bus.fwd_count, 16'hFFFF);
    @(negedge clk);
    #1 chk("fwd_count_wrap", bus.fwd_count, 16'h0000);
    chk("stall_count_wrap_run", bus.stall_count, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
